// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery domain converter.
// Width, direction encodings and FSM state encoding.
package mont_pkg;

    localparam int MONT_WIDTH = 6;

    localparam logic DIR_TO   = 1'b0;
    localparam logic DIR_FROM = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REDUCE,
        ST_SCALE,
        ST_FIX
    } mont_state_e;

endpackage

// File: rtl/mont_cond_sub.sv
// Conditional subtract: y = (r >= m) ? r - m : r, at WIDTH+1 bits.
// Shared by the reduce, encode-scale and final fix steps.
module mont_cond_sub #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   y
);

    logic [WIDTH:0] m_ext;

    assign m_ext = {1'b0, m};
    assign y     = (r >= m_ext) ? (r - m_ext) : r;

endmodule

// File: rtl/mont_domain_converter.sv
// Bit-serial conversion into (A*R mod M) and out of (A*R^-1 mod M)
// the Montgomery domain, R = 2^WIDTH, one iteration per clock.
module mont_domain_converter
    import mont_pkg::*;
#(
    parameter int WIDTH = MONT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] M,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Z,
    output logic             err
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    mont_state_e    state_q, state_d;
    logic [WIDTH:0] r_q, r_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic           dir_q, dir_d;
    logic           bad_q, bad_d;
    logic           busy_d, done_d, err_d;
    logic [WIDTH-1:0] z_d;

    logic [WIDTH:0] sub_in, sub_out;
    logic [WIDTH:0] half_sum;
    logic           m_illegal;

    assign m_illegal = !M[0] || (M == WIDTH'(1));

    mont_cond_sub #(.WIDTH(WIDTH)) u_sub (
        .r (sub_in),
        .m (m_q),
        .y (sub_out)
    );

    // Decode step: make r even by adding M, then halve.
    assign half_sum = r_q + (r_q[0] ? {1'b0, m_q} : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            m_q     <= '0;
            dir_q   <= DIR_TO;
            bad_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            Z       <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            m_q     <= m_d;
            dir_q   <= dir_d;
            bad_q   <= bad_d;
            busy    <= busy_d;
            done    <= done_d;
            Z       <= z_d;
            err     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        m_d     = m_q;
        dir_d   = dir_q;
        bad_d   = bad_q;
        busy_d  = busy;
        done_d  = 1'b0;
        z_d     = Z;
        err_d   = err;
        sub_in  = r_q;

        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_d    = A;
                    m_d    = M;
                    dir_d  = dir;
                    bad_d  = m_illegal;
                    busy_d = 1'b1;
                    cnt_d  = CNT_LOAD;
                    r_d    = (dir == DIR_FROM) ? {1'b0, A} : '0;
                    if (m_illegal)
                        state_d = ST_FIX;
                    else if (dir == DIR_TO)
                        state_d = ST_REDUCE;
                    else
                        state_d = ST_SCALE;
                end
            end
            ST_REDUCE: begin
                // a_q shifts left so its MSB is the next operand bit
                sub_in = {r_q[WIDTH-1:0], a_q[WIDTH-1]};
                r_d    = sub_out;
                a_d    = {a_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_SCALE;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_SCALE: begin
                if (dir_q == DIR_TO) begin
                    sub_in = {r_q[WIDTH-1:0], 1'b0};
                    r_d    = sub_out;
                end else begin
                    r_d = {1'b0, half_sum[WIDTH:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_FIX: begin
                sub_in  = r_q;
                done_d  = 1'b1;
                err_d   = bad_q;
                z_d     = bad_q ? '0 : sub_out[WIDTH-1:0];
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
